// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle CPU main controller.
// The datapath and the ALU control decoder use the same encodings.
package multicycle_ctrl_pkg;

    localparam int OPW    = 4;
    localparam int STATEW = 4;

    typedef enum logic [STATEW-1:0] {
        S_IDLE     = 4'h0,
        S_FETCH    = 4'h1,
        S_DECODE   = 4'h2,
        S_EXEC_R   = 4'h3,
        S_EXEC_I   = 4'h4,
        S_ALU_WB   = 4'h5,
        S_MEM_ADDR = 4'h6,
        S_MEM_RD   = 4'h7,
        S_MEM_WB   = 4'h8,
        S_MEM_WR   = 4'h9,
        S_BRANCH   = 4'hA,
        S_JUMP     = 4'hB,
        S_HALT     = 4'hC
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = 4'd0;
    localparam logic [OPW-1:0] OP_ADDI  = 4'd1;
    localparam logic [OPW-1:0] OP_ORI   = 4'd2;
    localparam logic [OPW-1:0] OP_LW    = 4'd3;
    localparam logic [OPW-1:0] OP_SW    = 4'd4;
    localparam logic [OPW-1:0] OP_BEQ   = 4'd5;
    localparam logic [OPW-1:0] OP_J     = 4'd6;
    localparam logic [OPW-1:0] OP_HALT  = 4'd7;

    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_ADD   = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the main controller (master) and the datapath (slave).
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    logic [OPW-1:0]    opcode;
    logic              alu_zero;
    logic              mem_ready;
    logic              mem_req;
    logic              mem_we;
    logic              iord;
    logic              ir_write;
    logic              pc_write;
    logic [1:0]        pc_src;
    logic              alu_src_a;
    logic [1:0]        alu_src_b;
    logic [1:0]        alu_op;
    logic              reg_write;
    logic              reg_dst;
    logic              mem_to_reg;
    logic              halted;
    logic              illegal_op;
    logic [STATEW-1:0] dbg_state;

    modport master (
        input  opcode, alu_zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
               mem_to_reg, halted, illegal_op, dbg_state
    );

    modport slave (
        output opcode, alu_zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
               mem_to_reg, halted, illegal_op, dbg_state
    );

endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: sequences fetch/decode/execute/memory/writeback.
// Outputs are a pure decode of the state register plus mem_ready, alu_zero and opcode.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:        state_d = S_EXEC_R;
                    OP_ADDI, OP_ORI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                    OP_BEQ:          state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_HALT:         state_d = S_HALT;
                    default:         state_d = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_IDLE;
        endcase
    end

    assign bus.dbg_state = state_q;

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = PCSRC_ALU;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_REGB;
        bus.alu_op     = ALUOP_FUNCT;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.halted     = 1'b0;
        bus.illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = SRCB_ONE;
                bus.alu_op    = ALUOP_ADD;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                bus.alu_src_b  = SRCB_SHIMM;
                bus.alu_op     = ALUOP_ADD;
                bus.illegal_op = (bus.opcode > OP_HALT);
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = (bus.opcode == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
            end
            S_ALU_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = (bus.opcode == OP_RTYPE);
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                bus.mem_we  = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALUOP_SUB;
                bus.pc_src    = PCSRC_ALUOUT;
                bus.pc_write  = bus.alu_zero;
            end
            S_JUMP: begin
                bus.pc_src   = PCSRC_JUMP;
                bus.pc_write = 1'b1;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
